verdict_collector: RTL and testbench

Downstream stage of the generated monitor (`topEntity`). Samples the monitor's per-stream outputs and `*_aktv` flags every cycle. Packs each cycle with at least one active output into a timestamped frame and buffers frames in a FIFO. Serializes them as one word per active stream over a valid/ready handshake toward the host/log interface.

---
 rtl/verdict_collector.sv | 196 +++++++++++++++++++
 tb/tb_verdict_collector.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/verdict_collector.sv
// verdict_collector
// ---------------------------------------------------------------------------
// Sits behind the generated monitor. On every enabled cycle where at least
// one output stream is active, it captures a frame {timestamp, active mask,
// all stream values} into a small frame FIFO. A serializer then emits each
// frame as one word per active stream, lowest stream index first, over a
// valid/ready handshake.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset (flushes FIFO, zeroes ts)
//   en         : capture / timestamp enable (same enable as the monitor)
//   out_value  : monitor outputs, stream i at [i*DATA_W +: DATA_W]
//   out_aktv   : per-stream active flags
//   tx_valid   : output word valid
//   tx_ready   : consumer accepts the word
//   tx_ts      : timestamp of the frame this word belongs to
//   tx_id      : stream index of this word
//   tx_value   : stream value
//   tx_last    : final word of the frame
//   drop       : one-cycle pulse after a frame was discarded (FIFO full)
//   drop_count : saturating 16-bit dropped-frame counter
//                (present only when VERDICT_COLLECTOR_DROP_CNT_EN is defined)
//
// Optional feature macro: VERDICT_COLLECTOR_DROP_CNT_EN
// ---------------------------------------------------------------------------
module verdict_collector #(
    parameter int NUM_OUT = 3,
    parameter int DATA_W  = 64,
    parameter int TS_W    = 32,
    parameter int DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_OUT*DATA_W-1:0] out_value,
    input  logic [NUM_OUT-1:0]        out_aktv,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [TS_W-1:0]           tx_ts,
    output logic [2:0]                tx_id,
    output logic [DATA_W-1:0]         tx_value,
    output logic                      tx_last,
    output logic                      drop
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
    ,
    output logic [15:0]               drop_count
`endif
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     ONE_CNT  = (AW+1)'(1);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    // Frame storage; the head frame stays in the FIFO until its last word
    // handshakes, so occupancy counts the frame being serialized too.
    logic [TS_W-1:0]           mem_ts_q   [DEPTH];
    logic [NUM_OUT-1:0]        mem_mask_q [DEPTH];
    logic [NUM_OUT*DATA_W-1:0] mem_val_q  [DEPTH];

    state_t              state_q;
    logic [TS_W-1:0]     ts_q;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q;
    logic [NUM_OUT-1:0]  rem_mask_q;
    logic                tx_valid_q, tx_last_q, drop_q;
    logic [TS_W-1:0]     tx_ts_q;
    logic [2:0]          tx_id_q;
    logic [DATA_W-1:0]   tx_value_q;

    logic                push_req, fifo_full, hs, pop, push, load;
    logic [AW-1:0]       ld_ptr;
    logic [NUM_OUT-1:0]  ld_mask, rem_d;
    logic [TS_W-1:0]     ld_ts;
    logic [NUM_OUT*DATA_W-1:0] ld_vals, cur_vals;

    function automatic logic [2:0] low_id(input logic [NUM_OUT-1:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic one_left(input logic [NUM_OUT-1:0] m);
        return (m != '0) && ((m & (m - NUM_OUT'(1))) == '0);
    endfunction

    function automatic logic [DATA_W-1:0] pick(input logic [NUM_OUT*DATA_W-1:0] v,
                                               input logic [2:0] id);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (id == 3'(i)) r = v[i*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    always_comb begin
        push_req  = en & (|out_aktv);
        fifo_full = (count_q == FULL_CNT);
        hs        = tx_valid_q & tx_ready;
        pop       = (state_q == S_EMIT) & hs & tx_last_q;
        // A full FIFO still accepts when the head frame retires this edge.
        push      = push_req & (~fifo_full | pop);
        // Load the head from IDLE, or the frame behind the retiring head so
        // frames stream back-to-back without a bubble.
        load      = ((state_q == S_IDLE) & (count_q != '0)) |
                    (pop & (count_q > ONE_CNT));
        ld_ptr    = (state_q == S_IDLE) ? rd_ptr_q : rd_ptr_q + AW'(1);
        ld_ts     = mem_ts_q[ld_ptr];
        ld_mask   = mem_mask_q[ld_ptr];
        ld_vals   = mem_val_q[ld_ptr];
        cur_vals  = mem_val_q[rd_ptr_q];
        // Clear the lowest set bit: the word just handshaken.
        rem_d     = rem_mask_q & (rem_mask_q - NUM_OUT'(1));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_ts_q[wr_ptr_q]   <= ts_q;
            mem_mask_q[wr_ptr_q] <= out_aktv;
            mem_val_q[wr_ptr_q]  <= out_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rem_mask_q <= '0;
            tx_valid_q <= 1'b0;
            tx_ts_q    <= '0;
            tx_id_q    <= '0;
            tx_value_q <= '0;
            tx_last_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            if (en) ts_q <= ts_q + TS_W'(1);
            drop_q <= push_req & fifo_full & ~pop;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

            if (load) begin
                state_q    <= S_EMIT;
                rem_mask_q <= ld_mask;
                tx_valid_q <= 1'b1;
                tx_ts_q    <= ld_ts;
                tx_id_q    <= low_id(ld_mask);
                tx_value_q <= pick(ld_vals, low_id(ld_mask));
                tx_last_q  <= one_left(ld_mask);
            end else if (state_q == S_EMIT && hs) begin
                if (tx_last_q) begin
                    state_q    <= S_IDLE;
                    rem_mask_q <= '0;
                    tx_valid_q <= 1'b0;
                    tx_last_q  <= 1'b0;
                end else begin
                    rem_mask_q <= rem_d;
                    tx_id_q    <= low_id(rem_d);
                    tx_value_q <= pick(cur_vals, low_id(rem_d));
                    tx_last_q  <= one_left(rem_d);
                end
            end
        end
    end

`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
    logic [15:0] drop_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_q <= '0;
        end else if (push_req & fifo_full & ~pop & (drop_count_q != 16'hFFFF)) begin
            drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign drop_count = drop_count_q;
`endif

    assign tx_valid = tx_valid_q;
    assign tx_ts    = tx_ts_q;
    assign tx_id    = tx_id_q;
    assign tx_value = tx_value_q;
    assign tx_last  = tx_last_q;
    assign drop     = drop_q;

endmodule

// File: tb/tb_verdict_collector.sv
// Directed testbench for verdict_collector with a word scoreboard.
module tb_verdict_collector;
    localparam int NUM_OUT = 3;
    localparam int DATA_W  = 64;
    localparam int TS_W    = 32;
    localparam int DEPTH   = 8;

    logic                      clk = 1'b0;
    logic                      rst, en, tx_ready;
    logic [NUM_OUT*DATA_W-1:0] out_value;
    logic [NUM_OUT-1:0]        out_aktv;
    logic                      tx_valid, tx_last, drop;
    logic [TS_W-1:0]           tx_ts;
    logic [2:0]                tx_id;
    logic [DATA_W-1:0]         tx_value;
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
    logic [15:0]               drop_count;
`endif

    verdict_collector #(
        .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .out_value(out_value), .out_aktv(out_aktv),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_ts(tx_ts), .tx_id(tx_id), .tx_value(tx_value),
        .tx_last(tx_last), .drop(drop)
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [2:0]        id;
        logic [DATA_W-1:0] val;
        logic              last;
    } word_t;

    word_t           sb[$];
    int              n_assert = 0;
    int              n_fail   = 0;
    int              occ_m    = 0;
    int              drops_seen = 0;
    logic [TS_W-1:0] ts_m     = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge, advance, then check the outputs #1 later.
    task automatic step();
        logic              hs, pv, push_req, accepted, pop_last, exp_drop;
        logic [TS_W-1:0]   p_ts;
        logic [2:0]        p_id;
        logic [DATA_W-1:0] p_val;
        logic              p_last;
        int                occ_before;
        word_t             w;
        pv = tx_valid; p_ts = tx_ts; p_id = tx_id; p_val = tx_value; p_last = tx_last;
        hs = tx_valid && tx_ready && !rst;
        pop_last = 1'b0;
        occ_before = occ_m;
        if (hs) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 128'(sb.size()), 128'(1));
            end else begin
                w = sb.pop_front();
                chk("tx_ts",    128'(tx_ts),    128'(w.ts));
                chk("tx_id",    128'(tx_id),    128'(w.id));
                chk("tx_value", 128'(tx_value), 128'(w.val));
                chk("tx_last",  128'(tx_last),  128'(w.last));
                pop_last = w.last;
            end
        end
        push_req = en && (out_aktv != '0) && !rst;
        accepted = push_req && (occ_m < DEPTH || pop_last);
        exp_drop = push_req && !accepted;
        if (pop_last) occ_m--;
        if (accepted) begin
            occ_m++;
            for (int i = 0; i < NUM_OUT; i++) begin
                if (out_aktv[i]) begin
                    w.ts   = ts_m;
                    w.id   = 3'(i);
                    w.val  = out_value[i*DATA_W +: DATA_W];
                    w.last = ((out_aktv >> (i + 1)) == '0);
                    sb.push_back(w);
                end
            end
        end
        if (rst) begin
            sb.delete();
            occ_m = 0;
            ts_m  = '0;
        end else if (en) begin
            ts_m++;
        end
        @(posedge clk);
        #1;
        chk("drop", 128'(drop), 128'(exp_drop));
        if (drop) drops_seen++;
        if (rst) begin
            chk("rst_valid", 128'(tx_valid), 128'(0));
        end else if (pv === 1'b1 && !hs) begin
            chk("hold_valid", 128'(tx_valid), 128'(1));
            chk("hold_ts",    128'(tx_ts),    128'(p_ts));
            chk("hold_id",    128'(tx_id),    128'(p_id));
            chk("hold_value", 128'(tx_value), 128'(p_val));
            chk("hold_last",  128'(tx_last),  128'(p_last));
        end else if (hs && (!pop_last || occ_before > 1)) begin
            chk("no_bubble", 128'(tx_valid), 128'(1));
        end
    endtask

    task automatic frame(input logic [2:0] m, input logic [63:0] v0, v1, v2);
        out_aktv  = m;
        out_value = {v2, v1, v0};
        step();
        out_aktv  = '0;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && (sb.size() != 0 || tx_valid); i++) step();
        chk("drain_sb",   128'(sb.size()), 128'(0));
        chk("drain_idle", 128'(tx_valid),  128'(0));
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && !tx_valid; i++) step();
        chk("valid_rise", 128'(tx_valid), 128'(1));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; tx_ready = 1'b0;
        out_aktv = '0; out_value = '0;
        step();
        step();
        chk("rst_ts",    128'(tx_ts),    128'(0));
        chk("rst_id",    128'(tx_id),    128'(0));
        chk("rst_value", 128'(tx_value), 128'(0));
        chk("rst_last",  128'(tx_last),  128'(0));
        chk("rst_drop",  128'(drop),     128'(0));
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
        chk("rst_drop_count", 128'(drop_count), 128'(0));
`endif
        rst = 1'b0;

        // Single full frame, latency and back-to-back words.
        en = 1'b1; tx_ready = 1'b1;
        frame(3'b111, 64'd1, 64'd2, 64'd3);
        chk("lat_k", 128'(tx_valid), 128'(0));
        step();
        chk("lat_k1", 128'(tx_valid), 128'(1));
        drain(20);
        $display("single frame done");

        // Frozen timestamp while en=0, then a sparse mask.
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        frame(3'b101, 64'd7, 64'd5, 64'd9);
        drain(20);
        $display("sparse mask done");

        // Backpressure: ten stalled cycles with the word held.
        tx_ready = 1'b0;
        frame(3'b111, 64'hA, 64'hB, 64'hC);
        wait_valid(5);
        repeat (10) step();
        tx_ready = 1'b1;
        drain(20);
        $display("backpressure done");

        // Overflow: ten frames into an eight-deep FIFO.
        tx_ready = 1'b0;
        drops_seen = 0;
        for (int k = 0; k < 10; k++) frame(3'b001, 64'(100 + k), 64'd0, 64'd0);
        chk("drop_pulses", 128'(drops_seen), 128'(2));
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
        chk("drop_count", 128'(drop_count), 128'(2));
`endif
        tx_ready = 1'b1;
        drain(60);
        $display("overflow done");

        // Full FIFO with head retiring on the same edge as a new capture.
        tx_ready = 1'b0;
        for (int k = 0; k < 8; k++) frame(3'b001, 64'(200 + k), 64'd0, 64'd0);
        tx_ready = 1'b1;
        frame(3'b010, 64'd0, 64'h55, 64'd0);
        chk("fullpop_drop", 128'(drop), 128'(0));
        drain(60);
        $display("full plus pop done");

        // Reset during word 2 of 3, then timestamps restart from 0.
        tx_ready = 1'b0;
        frame(3'b111, 64'd11, 64'd22, 64'd33);
        wait_valid(5);
        tx_ready = 1'b1;
        step();
        chk("mid_frame_id", 128'(tx_id), 128'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        frame(3'b011, 64'h77, 64'h88, 64'd0);
        drain(20);
        $display("reset mid-frame done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
